poly_bank_reader: RTL and testbench

//   Read-side master for a poly_bank: fetches a run of coefficients starting at base_addr and

---
 rtl/poly_bank_reader_pkg.sv | 14 +
 rtl/poly_skid_fifo.sv | 52 +++++
 rtl/poly_bank_reader.sv | 98 +++++++++
 tb/tb_poly_bank_reader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/poly_bank_reader_pkg.sv
// Shared definitions for the poly_bank read-side master: default geometry and FSM encoding.
package poly_bank_reader_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/poly_skid_fifo.sv
// Two-entry FIFO with a registered head word; absorbs the bank read latency under backpressure.
module poly_skid_fifo #(
  parameter int width = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] head,
  output logic [1:0]       count
);

  logic [width-1:0] head_q;
  logic [width-1:0] tail_q;
  logic [1:0]       count_q;
  logic             pop;

  assign pop   = (count_q != 2'd0) && ready;
  assign valid = (count_q != 2'd0);
  assign head  = head_q;
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the data registers carry no reset; count_q alone decides whether they hold anything.
  always_ff @(posedge clk) begin
    if (pop) begin
      head_q <= (push && count_q == 2'd1) ? push_data : tail_q;
    end else if (push && count_q == 2'd0) begin
      head_q <= push_data;
    end
    if (push && ((count_q == 2'd1 && !pop) || count_q == 2'd2)) begin
      tail_q <= push_data;
    end
  end

  overflow_check : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count_q == 2'd2));

endmodule

// File: rtl/poly_bank_reader.sv
// Read-side master for poly_bank: issues reads from base_addr for len words and streams them out
// on valid/ready, keeping at most two words either buffered or in flight.
module poly_bank_reader
  import poly_bank_reader_pkg::*;
#(
  parameter int addr_width = DEF_ADDR_WIDTH,
  parameter int depth      = DEF_DEPTH,
  parameter int data_width = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] bank_raddr,
  input  logic [data_width-1:0] bank_dout,
  output logic                  m_valid,
  output logic [data_width-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  state_e                state_q, state_d;
  logic [addr_width-1:0] cur_addr_q;
  logic [addr_width-1:0] raddr_q;
  logic [addr_width:0]   remaining_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  issue;
  logic                  pop;
  logic                  drain_done;
  logic [2:0]            backlog;
  logic [1:0]            fifo_count;
  logic [data_width:0]   fifo_head;

  assign pop     = m_valid && m_ready;
  // Words already buffered plus the one in flight must leave room for the new read.
  assign backlog = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign issue   = (state_q == ST_RUN) && (backlog < (3'd2 + {2'b00, pop}));

  assign bank_raddr = issue ? cur_addr_q : raddr_q;

  assign drain_done = (state_q == ST_DRAIN) && (fifo_count == 2'd0) && !inflight_q;
  assign done       = drain_done;
  assign busy       = (state_q != ST_IDLE) && !drain_done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (len == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (issue && remaining_q == (addr_width+1)'(1)) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      raddr_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      raddr_q         <= bank_raddr;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == (addr_width+1)'(1));
      if (state_q == ST_IDLE && start) begin
        cur_addr_q  <= base_addr;
        remaining_q <= len;
      end else if (issue) begin
        cur_addr_q  <= (cur_addr_q == addr_width'(depth - 1)) ? '0 : cur_addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
    end
  end

  poly_skid_fifo #(
    .width (data_width + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({inflight_last_q, bank_dout}),
    .ready     (m_ready),
    .valid     (m_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign m_data = fifo_head[data_width-1:0];
  assign m_last = fifo_head[data_width];

endmodule

// File: tb/tb_poly_bank_reader.sv
// Directed bench for poly_bank_reader paired with a behavioural poly_bank holding bank[i] = i*3.
module tb_poly_bank_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  len;
  logic        busy;
  logic        done;
  logic [4:0]  bank_raddr;
  logic [23:0] bank_dout;
  logic        m_valid;
  logic [23:0] m_data;
  logic        m_last;
  logic        m_ready;

  logic [23:0] bank_mem [32];

  int checks   = 0;
  int failures = 0;

  int got_data[$];
  int got_last[$];
  int hs_cyc[$];
  int first_valid, done_cycle, done_count, stable_err, max_occ, busy_c1, busy_at_done;
  int raddr_log[16];

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) bank_mem[i] = 24'(i * 3);
  always @(posedge clk) bank_dout <= bank_mem[bank_raddr];

  poly_bank_reader #(
    .addr_width (5),
    .depth      (32),
    .data_width (24)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .bank_raddr (bank_raddr),
    .bank_dout  (bank_dout),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a transfer at the negedge before E0 and monitors it; cycle n is the n-th cycle after E0.
  task automatic run_xfer(input string tag, input int base, input int n, input int rmode,
                          input bit restart_mid);
    bit          stalled = 1'b0;
    logic [23:0] held_data = '0;
    logic        held_last = 1'b0;
    got_data.delete(); got_last.delete(); hs_cyc.delete();
    first_valid = -1; done_cycle = -1; done_count = 0; stable_err = 0;
    max_occ = 0; busy_c1 = -1; busy_at_done = -1;
    foreach (raddr_log[i]) raddr_log[i] = -1;
    @(negedge clk);
    base_addr = base[4:0];
    len       = n[5:0];
    start     = 1'b1;
    m_ready   = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start     = restart_mid && (cyc == 4);
      base_addr = restart_mid ? 5'd10 : base[4:0];
      m_ready   = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
      #1;
      if (cyc < 16) raddr_log[cyc] = int'(bank_raddr);
      if (cyc == 1) busy_c1 = int'(busy);
      if (int'(dut.u_fifo.count_q) > max_occ) max_occ = int'(dut.u_fifo.count_q);
      if (stalled && (m_data !== held_data || m_last !== held_last)) stable_err++;
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
        got_data.push_back(int'(m_data));
        got_last.push_back(int'(m_last));
        hs_cyc.push_back(cyc);
      end
      stalled   = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
      if (done) begin
        done_count++;
        if (done_cycle < 0) begin
          done_cycle   = cyc;
          busy_at_done = int'(busy);
        end
      end
      if (done_cycle >= 0 && cyc >= done_cycle + 3) break;
    end
    check({tag, " done_seen"}, done_cycle >= 0, 1'b1);
  endtask

  task automatic verify(input string tag, input int base, input int n);
    check({tag, " words"}, got_data.size(), n);
    for (int i = 0; i < got_data.size() && i < n; i++) begin
      check($sformatf("%s data[%0d]", tag, i), got_data[i], ((base + i) % 32) * 3);
      check($sformatf("%s last[%0d]", tag, i), got_last[i], (i == n - 1));
    end
    check({tag, " done_count"}, done_count, 1);
    check({tag, " busy_at_done"}, busy_at_done, 0);
    check({tag, " stall_stable"}, stable_err, 0);
    check({tag, " occ_le_2"}, max_occ <= 2, 1'b1);
    if (n > 0 && hs_cyc.size() > 0)
      check({tag, " done_after_last"}, done_cycle, hs_cyc[hs_cyc.size() - 1] + 1);
  endtask

  initial begin
    int hs;
    int dones;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst m_valid", m_valid, 0);
    check("rst m_last", m_last, 0);
    check("rst raddr", bank_raddr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: base=4 len=8 full throughput
    run_xfer("t1", 4, 8, 0, 1'b0);
    verify("t1", 4, 8);
    check("t1 first_valid", first_valid, 3);
    check("t1 done_cycle", done_cycle, 11);
    check("t1 busy_c1", busy_c1, 1);
    check("t1 data0", got_data.size() > 0 ? got_data[0] : -1, 12);
    check("t1 data7", got_data.size() > 7 ? got_data[7] : -1, 33);
    check("t1 span", hs_cyc.size() == 8 ? hs_cyc[7] - hs_cyc[0] : -1, 7);

    // 2: wrap-around
    run_xfer("t2", 30, 4, 0, 1'b0);
    verify("t2", 30, 4);
    check("t2 raddr1", raddr_log[1], 30);
    check("t2 raddr2", raddr_log[2], 31);
    check("t2 raddr3", raddr_log[3], 0);
    check("t2 raddr4", raddr_log[4], 1);
    check("t2 data1", got_data.size() > 1 ? got_data[1] : -1, 93);
    check("t2 data2", got_data.size() > 2 ? got_data[2] : -1, 0);

    // 3: backpressure pattern 1,0,0
    run_xfer("t3", 0, 6, 1, 1'b0);
    verify("t3", 0, 6);

    // 4: zero-length transfer
    run_xfer("t4", 7, 0, 0, 1'b0);
    verify("t4", 7, 0);
    check("t4 done_cycle", done_cycle, 1);
    check("t4 no_valid", first_valid, -1);

    // 5: start re-pulsed mid-transfer with base=10 is ignored
    run_xfer("t5", 4, 8, 0, 1'b1);
    verify("t5", 4, 8);
    check("t5 done_cycle", done_cycle, 11);

    // 6: reset after 3 words of a len=8 transfer
    @(negedge clk);
    base_addr = 5'd0; len = 6'd8; start = 1'b1; m_ready = 1'b1;
    hs = 0;
    for (int cyc = 1; cyc <= 50 && hs < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (m_valid && m_ready) hs++;
    end
    check("t6 three_words", hs, 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6 busy", busy, 0);
    check("t6 m_valid", m_valid, 0);
    check("t6 done", done, 0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (done || m_valid) dones++;
    end
    check("t6 quiet", dones, 0);
    run_xfer("t6b", 8, 4, 0, 1'b0);
    verify("t6b", 8, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
